// File: rtl/ball_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ball_ctrl
// Description : Pong ball engine. Advances the ball once per frame, bounces it
//               off walls and paddles, detects misses and keeps both scores.
// Revision    : 1.0 - initial release
// ============================================================================
module ball_ctrl #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int BALL_SIZE   = 8,
    parameter int STEP_X      = 2,
    parameter int STEP_Y      = 2,
    parameter int PADDLE_H    = 96,
    parameter int PADDLE_W    = 15,
    parameter int P1_X        = 30,
    parameter int P2_X        = 595,
    parameter int HOLD_FRAMES = 60,
    parameter int MAX_SCORE   = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       serve,
    input  logic [9:0] p1_y,
    input  logic [9:0] p2_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic       point_p1,
    output logic       point_p2,
    output logic       game_over
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_move   = 2'd1;
    localparam logic [1:0] c_st_scored = 2'd2;
    localparam logic [1:0] c_st_over   = 2'd3;

    localparam logic [10:0] c_max_x     = 11'(H_RES - BALL_SIZE);
    localparam logic [10:0] c_max_y     = 11'(V_RES - BALL_SIZE);
    localparam logic [10:0] c_centre_x  = 11'((H_RES - BALL_SIZE) / 2);
    localparam logic [10:0] c_centre_y  = 11'((V_RES - BALL_SIZE) / 2);
    localparam logic [10:0] c_step_x    = 11'(STEP_X);
    localparam logic [10:0] c_step_y    = 11'(STEP_Y);
    localparam logic [10:0] c_size      = 11'(BALL_SIZE);
    localparam logic [10:0] c_h_res     = 11'(H_RES);
    localparam logic [10:0] c_v_res     = 11'(V_RES);
    localparam logic [10:0] c_paddle_h  = 11'(PADDLE_H);
    localparam logic [10:0] c_p1_edge   = 11'(P1_X + PADDLE_W);
    localparam logic [10:0] c_p2_x      = 11'(P2_X);
    localparam logic [3:0]  c_max_score = 4'(MAX_SCORE);
    localparam int          c_hold_w    = $clog2(HOLD_FRAMES + 1);
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_FRAMES - 1);

    logic [1:0]          r_state;
    logic [9:0]          r_ball_x;
    logic [9:0]          r_ball_y;
    logic                r_dir_x;   // 1 = right
    logic                r_dir_y;   // 1 = down
    logic [3:0]          r_score_p1;
    logic [3:0]          r_score_p2;
    logic                r_point_p1;
    logic                r_point_p2;
    logic                r_game_over;
    logic [c_hold_w-1:0] r_hold_cnt;

    logic [10:0] w_x, w_y, w_p1, w_p2;
    logic [10:0] w_nx, w_ny;
    logic        w_ndx, w_ndy, w_ov1, w_ov2, w_miss_l, w_miss_r;
    logic [3:0]  w_s1_inc, w_s2_inc;

    function automatic logic [9:0] clamp(input logic [10:0] v, input logic [10:0] hi);
        return (v > hi) ? hi[9:0] : v[9:0];
    endfunction

    assign w_x  = {1'b0, r_ball_x};
    assign w_y  = {1'b0, r_ball_y};
    assign w_p1 = {1'b0, p1_y};
    assign w_p2 = {1'b0, p2_y};

    assign w_ov1 = (w_y + c_size > w_p1) && (w_y < w_p1 + c_paddle_h);
    assign w_ov2 = (w_y + c_size > w_p2) && (w_y < w_p2 + c_paddle_h);

    assign w_s1_inc = (r_score_p1 >= c_max_score) ? c_max_score : r_score_p1 + 4'd1;
    assign w_s2_inc = (r_score_p2 >= c_max_score) ? c_max_score : r_score_p2 + 4'd1;

    always_comb begin
        w_ny     = w_y;
        w_ndy    = r_dir_y;
        w_nx     = w_x;
        w_ndx    = r_dir_x;
        w_miss_l = 1'b0;
        w_miss_r = 1'b0;

        if (!r_dir_y) begin
            if (w_y <= c_step_y) begin
                w_ny  = '0;
                w_ndy = 1'b1;
            end else begin
                w_ny = w_y - c_step_y;
            end
        end else if (w_y + c_size + c_step_y >= c_v_res) begin
            w_ny  = c_max_y;
            w_ndy = 1'b0;
        end else begin
            w_ny = w_y + c_step_y;
        end

        // Paddle face crossing is checked before the miss edge so a hit always wins.
        if (!r_dir_x) begin
            if (w_x > c_p1_edge && w_x - c_step_x <= c_p1_edge && w_ov1) begin
                w_nx  = c_p1_edge + 11'd1;
                w_ndx = 1'b1;
            end else if (w_x <= c_step_x) begin
                w_miss_l = 1'b1;
            end else begin
                w_nx = w_x - c_step_x;
            end
        end else begin
            if (w_x + c_size <= c_p2_x && w_x + c_size + c_step_x > c_p2_x && w_ov2) begin
                w_nx  = c_p2_x - c_size;
                w_ndx = 1'b0;
            end else if (w_x + c_size + c_step_x >= c_h_res) begin
                w_miss_r = 1'b1;
            end else begin
                w_nx = w_x + c_step_x;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_ball_x    <= c_centre_x[9:0];
            r_ball_y    <= c_centre_y[9:0];
            r_dir_x     <= 1'b1;
            r_dir_y     <= 1'b1;
            r_score_p1  <= '0;
            r_score_p2  <= '0;
            r_point_p1  <= 1'b0;
            r_point_p2  <= 1'b0;
            r_game_over <= 1'b0;
            r_hold_cnt  <= '0;
        end else begin
            r_point_p1 <= 1'b0;
            r_point_p2 <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (serve) r_state <= c_st_move;
                end
                c_st_move: begin
                    if (frame_tick) begin
                        if (w_miss_l || w_miss_r) begin
                            // Recentre and serve toward the side that conceded.
                            r_ball_x   <= c_centre_x[9:0];
                            r_ball_y   <= c_centre_y[9:0];
                            r_dir_x    <= w_miss_r;
                            r_hold_cnt <= '0;
                            if (w_miss_r) begin
                                r_point_p1 <= 1'b1;
                                r_score_p1 <= w_s1_inc;
                            end else begin
                                r_point_p2 <= 1'b1;
                                r_score_p2 <= w_s2_inc;
                            end
                            if ((w_miss_r ? w_s1_inc : w_s2_inc) == c_max_score) begin
                                r_state     <= c_st_over;
                                r_game_over <= 1'b1;
                            end else begin
                                r_state <= c_st_scored;
                            end
                        end else begin
                            r_ball_x <= clamp(w_nx, c_max_x);
                            r_ball_y <= clamp(w_ny, c_max_y);
                            r_dir_x  <= w_ndx;
                            r_dir_y  <= w_ndy;
                        end
                    end
                end
                c_st_scored: begin
                    if (frame_tick) begin
                        if (r_hold_cnt == c_hold_last) begin
                            r_hold_cnt <= '0;
                            r_state    <= c_st_idle;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end
                end
                c_st_over: begin
                    if (serve) begin
                        r_state     <= c_st_idle;
                        r_game_over <= 1'b0;
                        r_score_p1  <= '0;
                        r_score_p2  <= '0;
                        r_ball_x    <= c_centre_x[9:0];
                        r_ball_y    <= c_centre_y[9:0];
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign ball_x    = r_ball_x;
    assign ball_y    = r_ball_y;
    assign score_p1  = r_score_p1;
    assign score_p2  = r_score_p2;
    assign point_p1  = r_point_p1;
    assign point_p2  = r_point_p2;
    assign game_over = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_ball_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ball_ctrl
// Description : Randomised scoreboard bench for ball_ctrl against a frame-level
//               model of the game rules.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ball_ctrl;

    localparam int CX = 316, CY = 236, HOLD = 60, MAXS = 9;
    localparam int PH_IDLE = 0, PH_MOVE = 1, PH_SCORED = 2, PH_OVER = 3;

    logic       clk = 1'b0, reset = 1'b0, frame_tick = 1'b0, serve = 1'b0;
    logic [9:0] p1_y = 10'd900, p2_y = 10'd900;
    logic [9:0] ball_x, ball_y;
    logic [3:0] score_p1, score_p2;
    logic       point_p1, point_p2, game_over;

    always #5 clk = ~clk;

    ball_ctrl dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .serve(serve),
        .p1_y(p1_y), .p2_y(p2_y), .ball_x(ball_x), .ball_y(ball_y),
        .score_p1(score_p1), .score_p2(score_p2), .point_p1(point_p1),
        .point_p2(point_p2), .game_over(game_over)
    );

    typedef struct { int x; int y; int s1; int s2; int pt1; int pt2; int go; } exp_t;
    exp_t q[$];
    exp_t last_e, cur_e;
    int checks = 0, errors = 0;
    bit started = 0;
    logic ev_s = 1'b0;

    // Reference model state: position, direction as +1/-1, scores, hold count.
    int m_ph, mx, my, mdx, mdy, ms1, ms2, mhold;

    task automatic chk(input string name, input logic [31:0] act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic compare(input exp_t e);
        chk("ball_x", 32'(ball_x), e.x);
        chk("ball_y", 32'(ball_y), e.y);
        chk("score_p1", 32'(score_p1), e.s1);
        chk("score_p2", 32'(score_p2), e.s2);
        chk("point_p1", 32'(point_p1), e.pt1);
        chk("point_p2", 32'(point_p2), e.pt2);
        chk("game_over", 32'(game_over), e.go);
    endtask

    task automatic model(input bit tk, input bit sv, input bit rs, input int p1, input int p2);
        exp_t e;
        int nx, ny, ndx, ndy, miss;
        bit ov1, ov2;
        int pt1 = 0, pt2 = 0;
        if (rs) begin
            m_ph = PH_IDLE; mx = CX; my = CY; mdx = 1; mdy = 1;
            ms1 = 0; ms2 = 0; mhold = 0;
        end else begin
            case (m_ph)
                PH_IDLE: if (sv) m_ph = PH_MOVE;
                PH_MOVE: if (tk) begin
                    ndy = mdy;
                    if (mdy < 0) begin
                        if (my <= 2) begin ny = 0; ndy = 1; end else ny = my - 2;
                    end else if (my + 10 >= 480) begin
                        ny = 472; ndy = -1;
                    end else ny = my + 2;
                    ov1 = (my + 8 > p1) && (my < p1 + 96);
                    ov2 = (my + 8 > p2) && (my < p2 + 96);
                    miss = 0; nx = mx; ndx = mdx;
                    if (mdx < 0) begin
                        if (mx > 45 && mx - 2 <= 45 && ov1) begin nx = 46; ndx = 1; end
                        else if (mx <= 2) miss = 2;
                        else nx = mx - 2;
                    end else begin
                        if (mx + 8 <= 595 && mx + 10 > 595 && ov2) begin nx = 587; ndx = -1; end
                        else if (mx + 10 >= 640) miss = 1;
                        else nx = mx + 2;
                    end
                    if (miss != 0) begin
                        mx = CX; my = CY; mhold = 0;
                        if (miss == 1) begin
                            pt1 = 1; mdx = 1;
                            if (ms1 < MAXS) ms1++;
                        end else begin
                            pt2 = 1; mdx = -1;
                            if (ms2 < MAXS) ms2++;
                        end
                        m_ph = ((miss == 1 ? ms1 : ms2) == MAXS) ? PH_OVER : PH_SCORED;
                    end else begin
                        mx = nx; my = ny; mdx = ndx; mdy = ndy;
                    end
                end
                PH_SCORED: if (tk) begin
                    mhold++;
                    if (mhold == HOLD) begin m_ph = PH_IDLE; mhold = 0; end
                end
                PH_OVER: if (sv) begin
                    m_ph = PH_IDLE; ms1 = 0; ms2 = 0; mx = CX; my = CY;
                end
                default: ;
            endcase
        end
        e.x = mx; e.y = my; e.s1 = ms1; e.s2 = ms2;
        e.pt1 = pt1; e.pt2 = pt2; e.go = (m_ph == PH_OVER) ? 1 : 0;
        q.push_back(e);
    endtask

    task automatic step(input bit tk, input bit sv, input bit rs, input int p1, input int p2, input int gap);
        @(posedge clk); #2;
        p1_y = 10'(p1); p2_y = 10'(p2);
        frame_tick = tk; serve = sv; reset = rs;
        if (tk || sv || rs) model(tk, sv, rs, p1, p2);
        @(posedge clk); #2;
        frame_tick = 1'b0; serve = 1'b0; reset = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    function automatic int track(input int y, input int pct);
        int p;
        if (int'($urandom_range(0, 99)) < pct) begin
            p = y - int'($urandom_range(0, 88));
            return (p < 0) ? 0 : p;
        end
        return int'($urandom_range(0, 1023));
    endfunction

    // Monitor: the cycle after an event must show the queued expectation;
    // every other cycle must hold the last state with no point pulses.
    always @(posedge clk) ev_s <= frame_tick | serve | reset;

    always @(negedge clk) begin
        if (ev_s) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard_empty actual=0 required=1");
            end else begin
                cur_e = q.pop_front();
                last_e = cur_e;
                started = 1;
                compare(cur_e);
            end
        end else if (started) begin
            cur_e = last_e;
            cur_e.pt1 = 0; cur_e.pt2 = 0;
            compare(cur_e);
        end
    end

    initial begin
        int n;
        step(0, 0, 1, 900, 900, 0);
        repeat (3) step(1, 0, 0, 900, 900, $urandom_range(0, 2));
        step(1, 1, 0, 900, 900, 0);
        repeat (10) step(1, 0, 0, 900, 900, 1);

        // Free play with mostly-tracking paddles, occasional serves.
        for (int i = 0; i < 1500; i++) begin
            n = int'($urandom_range(0, 15));
            step((n != 0), (n <= 1) || (m_ph == PH_IDLE && n < 6), 0,
                 track(my, 85), track(my, 85), $urandom_range(0, 2));
        end

        // Reset mid-MOVE.
        step(0, 0, 1, 900, 900, 0);
        step(0, 1, 0, 900, 900, 0);
        repeat (7) step(1, 0, 0, 900, 900, 0);
        step(0, 0, 1, 900, 900, 0);
        repeat (2) step(1, 0, 0, 900, 900, 0);

        // Reset mid-SCORED, then confirm a full hold runs from zero.
        step(0, 1, 0, 900, 900, 0);
        for (int i = 0; i < 400 && m_ph != PH_SCORED; i++) step(1, 0, 0, 900, 900, 0);
        repeat (5) step(1, 0, 0, 900, 900, 0);
        step(0, 0, 1, 900, 900, 0);
        step(0, 1, 0, 900, 900, 0);
        for (int i = 0; i < 400 && m_ph != PH_SCORED; i++) step(1, 0, 0, 900, 900, 0);
        repeat (HOLD + 2) step(1, 0, 0, 900, 900, 0);

        // Left player always returns, right never does: play to game over.
        n = 0;
        while (m_ph != PH_OVER && n < 6000) begin
            step(1, (m_ph == PH_IDLE), 0, track(my, 100), 900, 0);
            n++;
        end
        chk("reached_game_over", 32'(m_ph == PH_OVER), 1);
        repeat (5) step(1, 0, 0, track(my, 100), 900, 1);
        step(0, 1, 0, 900, 900, 0);
        step(1, 1, 0, 900, 900, 0);
        repeat (20) step(1, 0, 0, 900, 900, 0);

        repeat (3) @(posedge clk);
        chk("queue_drained", 32'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
